min2_scan_ctrl: RTL

MIN2_SCAN_CTRL -- requirements
Module: min2_scan_ctrl

---
 rtl/min2_scan_ctrl_pkg.sv | 20 ++
 rtl/min2_scan_ctrl_pick2_min4.sv | 45 ++++
 rtl/min2_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/min2_scan_ctrl_pkg.sv
// Shared definitions for the two-minimum scan controller.
// Holds the bank geometry, weight width, saturation limit and FSM state encoding.
package min2_scan_ctrl_pkg;

    localparam int DEPTH = 128;
    localparam int W     = 11;
    localparam int AW    = 7;

    localparam logic [W-1:0] SAT_MAX = 11'd2047;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        WR1,
        WR2,
        DONE
    } state_t;

endpackage

// File: rtl/min2_scan_ctrl_pick2_min4.sv
// pick2_min4: combinational selection of the two smallest nonzero of four candidates.
// Ports: val[4]/addr[4] candidates in priority order; min1/min2 (+addr) out, 0 when empty.
module pick2_min4
    import min2_scan_ctrl_pkg::*;
(
    input  logic [W-1:0] val  [4],
    input  logic [7:0]   addr [4],
    output logic [W-1:0] min1,
    output logic [7:0]   min1_addr,
    output logic [W-1:0] min2,
    output logic [7:0]   min2_addr
);

    logic       h1;
    logic       h2;
    logic [1:0] i1;
    logic [1:0] i2;

    // Strict less-than keeps the earlier candidate on ties, so the
    // retained pair beats new data and bank0 beats bank1.
    always_comb begin
        h1 = 1'b0;
        i1 = 2'd0;
        h2 = 1'b0;
        i2 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (val[i] != '0 && (!h1 || val[i] < val[i1])) begin
                h1 = 1'b1;
                i1 = i[1:0];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (val[i] != '0 && i[1:0] != i1 &&
                (!h2 || val[i] < val[i2])) begin
                h2 = 1'b1;
                i2 = i[1:0];
            end
        end
        min1      = h1 ? val[i1]  : '0;
        min1_addr = h1 ? addr[i1] : '0;
        min2      = h2 ? val[i2]  : '0;
        min2_addr = h2 ? addr[i2] : '0;
    end

endmodule

// File: rtl/min2_scan_ctrl.sv
// Scans two weight banks in lockstep, keeps the two smallest nonzero entries,
// and optionally merges them (sum into min1 slot, zero into min2 slot).
// Ports: clk/rst (sync, active-high); start/len/merge_en request; busy/done/found,
// min1/min2 with {index,bank} addresses; rd_en/rd_addr/rd_data0/1 bank read;
// wr_en0/wr_en1/wr_addr/wr_data bank write-back.
module min2_scan_ctrl
    import min2_scan_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    len,
    input  logic          merge_en,
    output logic          busy,
    output logic          done,
    output logic [1:0]    found,
    output logic [W-1:0]  min1,
    output logic [W-1:0]  min2,
    output logic [7:0]    min1_addr,
    output logic [7:0]    min2_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data0,
    input  logic [W-1:0]  rd_data1,
    output logic          wr_en0,
    output logic          wr_en1,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data
);

    state_t        state;
    state_t        state_d;
    logic [AW-1:0] idx;
    logic [AW-1:0] last;
    logic          merge_q;
    logic          vld;
    logic [AW-1:0] vld_idx;

    logic [W-1:0]  cand_val  [4];
    logic [7:0]    cand_addr [4];
    logic [W-1:0]  p1;
    logic [W-1:0]  p2;
    logic [7:0]    p1_addr;
    logic [7:0]    p2_addr;
    logic [1:0]    found_n;
    logic [W:0]    sum;
    logic [W-1:0]  sum_sat;

    assign cand_val[0]  = min1;
    assign cand_val[1]  = min2;
    assign cand_val[2]  = rd_data0;
    assign cand_val[3]  = rd_data1;
    assign cand_addr[0] = min1_addr;
    assign cand_addr[1] = min2_addr;
    assign cand_addr[2] = {vld_idx, 1'b0};
    assign cand_addr[3] = {vld_idx, 1'b1};

    pick2_min4 u_pick (
        .val       (cand_val),
        .addr      (cand_addr),
        .min1      (p1),
        .min1_addr (p1_addr),
        .min2      (p2),
        .min2_addr (p2_addr)
    );

    assign found_n = {1'b0, p1 != '0} + {1'b0, p2 != '0};
    assign sum     = {1'b0, min1} + {1'b0, min2};
    assign sum_sat = sum[W] ? SAT_MAX : sum[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            merge_q   <= 1'b0;
            vld       <= 1'b0;
            vld_idx   <= '0;
            found     <= '0;
            min1      <= '0;
            min2      <= '0;
            min1_addr <= '0;
            min2_addr <= '0;
        end else begin
            state   <= state_d;
            // Read data lags the strobe by one cycle; remember which index it is.
            vld     <= (state == SCAN);
            vld_idx <= idx;
            if (state == IDLE && start) begin
                idx       <= '0;
                last      <= (len >= 8'(DEPTH)) ? AW'(DEPTH - 1)
                                                : len[AW-1:0] - 1'b1;
                merge_q   <= merge_en;
                found     <= '0;
                min1      <= '0;
                min2      <= '0;
                min1_addr <= '0;
                min2_addr <= '0;
            end else begin
                if (state == SCAN) begin
                    idx <= idx + 1'b1;
                end
                if (vld) begin
                    found     <= found_n;
                    min1      <= p1;
                    min2      <= p2;
                    min1_addr <= p1_addr;
                    min2_addr <= p2_addr;
                end
            end
        end
    end

    // DRAIN ranks the final read, so the merge decision uses the fresh count.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = (len == 8'd0) ? DONE : SCAN;
            SCAN:    if (idx == last) state_d = DRAIN;
            DRAIN:   state_d = (merge_q && found_n == 2'd2) ? WR1 : DONE;
            WR1:     state_d = WR2;
            WR2:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        rd_en   = (state == SCAN);
        rd_addr = (state == SCAN) ? idx : '0;
        wr_en0  = 1'b0;
        wr_en1  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (state == WR1) begin
            wr_en0  = ~min1_addr[0];
            wr_en1  = min1_addr[0];
            wr_addr = min1_addr[7:1];
            wr_data = sum_sat;
        end else if (state == WR2) begin
            wr_en0  = ~min2_addr[0];
            wr_en1  = min2_addr[0];
            wr_addr = min2_addr[7:1];
            wr_data = '0;
        end
    end

endmodule
